// File: rtl/adc_scan_sched.sv
// Channel scheduler above the SPI ADC frame engine: merges one-shot requests with a
// round-robin scan and re-tags results for the converter's one-frame address pipeline.
module adc_scan_sched #(
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iRUN,
    input  logic [7:0]  iEN_MASK,
    input  logic [7:0]  iREQ,
    output logic        oSTART,
    output logic [2:0]  oCH,
    input  logic        iDONE,
    input  logic [11:0] iDATA,
    output logic        oVALID,
    output logic [2:0]  oVCH,
    output logic [11:0] oVDATA,
    output logic        oBUSY,
    output logic        oERR
);

    localparam int unsigned CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_pend;
    logic [2:0]         r_ptr, r_ch, r_prev_ch, r_vch;
    logic               r_cur_valid, r_cur_pend, r_prev_valid;
    logic               r_start, r_busy, r_valid, r_err;
    logic [11:0]        r_vdata;

    logic               w_go, w_cnt_last, w_gap_last;
    logic               w_load_sel, w_done, w_tmo;
    logic [7:0]         w_clr, w_pend_all;
    logic [2:0]         w_pend_ch, w_scan_ch, w_sel_ch;
    logic               w_scan_hit, w_sel_valid, w_sel_pend;

    assign w_go       = (r_pend != 8'd0) || (iRUN && (iEN_MASK != 8'd0)) || r_prev_valid;
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_gap_last = (r_cnt == CNT_W'(GAP - 1));

    // State register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (iDONE || w_cnt_last) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_last) w_state_nxt = w_go ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decoded from state and inputs
    always_comb begin
        w_load_sel = 1'b0;
        w_done     = 1'b0;
        w_tmo      = 1'b0;
        w_clr      = 8'd0;
        if ((r_state == S_IDLE || r_state == S_GAP) && w_state_nxt == S_ISSUE)
            w_load_sel = 1'b1;
        if (r_state == S_WAIT) begin
            w_done = iDONE;
            w_tmo  = !iDONE && w_cnt_last;
        end
        if (r_state == S_ISSUE && r_cur_pend)
            w_clr = 8'd1 << r_ch;
    end

    // Channel selection; pend|iREQ is the pending set that will be visible in ISSUE
    always_comb begin
        w_pend_all = r_pend | iREQ;
        w_pend_ch  = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (w_pend_all[i]) w_pend_ch = 3'(i);
        w_scan_hit = 1'b0;
        w_scan_ch  = r_ptr;
        for (int i = 1; i <= 8; i++) begin
            if (!w_scan_hit && iEN_MASK[3'(int'(r_ptr) + i)]) begin
                w_scan_hit = 1'b1;
                w_scan_ch  = 3'(int'(r_ptr) + i);
            end
        end
        w_sel_ch    = r_prev_ch;
        w_sel_valid = 1'b0;
        w_sel_pend  = 1'b0;
        if (w_pend_all != 8'd0) begin
            w_sel_ch    = w_pend_ch;
            w_sel_valid = 1'b1;
            w_sel_pend  = 1'b1;
        end else if (iRUN && w_scan_hit) begin
            w_sel_ch    = w_scan_ch;
            w_sel_valid = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_cnt        <= '0;
            r_pend       <= 8'd0;
            r_ptr        <= 3'd7;
            r_ch         <= 3'd0;
            r_cur_valid  <= 1'b0;
            r_cur_pend   <= 1'b0;
            r_prev_ch    <= 3'd0;
            r_prev_valid <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_vch        <= 3'd0;
            r_vdata      <= 12'd0;
            r_err        <= 1'b0;
        end else begin
            r_pend  <= (r_pend & ~w_clr) | iREQ;
            r_start <= (w_state_nxt == S_ISSUE);
            r_busy  <= (w_state_nxt != S_IDLE);
            if (r_state != w_state_nxt)
                r_cnt <= '0;
            else if (r_state == S_WAIT || r_state == S_GAP)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_load_sel) begin
                r_ch        <= w_sel_ch;
                r_cur_valid <= w_sel_valid;
                r_cur_pend  <= w_sel_pend;
                if (w_sel_valid && !w_sel_pend) r_ptr <= w_sel_ch;
            end
            // Result of this frame belongs to the channel addressed one frame earlier
            r_valid <= w_done && r_prev_valid;
            if (w_done && r_prev_valid) begin
                r_vch   <= r_prev_ch;
                r_vdata <= iDATA;
            end
            if (w_done) begin
                r_prev_ch    <= r_ch;
                r_prev_valid <= r_cur_valid;
            end
            if (w_tmo) begin
                r_prev_valid <= 1'b0;
                r_err        <= 1'b1;
            end
        end
    end

    assign oSTART = r_start;
    assign oCH    = r_ch;
    assign oVALID = r_valid;
    assign oVCH   = r_vch;
    assign oVDATA = r_vdata;
    assign oBUSY  = r_busy;
    assign oERR   = r_err;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched: table of frames with hand-computed tags and data,
// plus hand-written collision, timeout and mid-frame reset sequences.
module tb_adc_scan_sched;

    logic        iCLK = 1'b0;
    logic        iRST, iRUN, iDONE;
    logic [7:0]  iEN_MASK, iREQ;
    logic [11:0] iDATA;
    logic        oSTART, oVALID, oBUSY, oERR;
    logic [2:0]  oCH, oVCH;
    logic [11:0] oVDATA;

    int n_vec    = 0;
    int n_bad    = 0;
    int n_valids = 0;
    int n_starts = 0;

    adc_scan_sched #(.GAP(2), .TIMEOUT(64)) dut (
        .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iEN_MASK(iEN_MASK), .iREQ(iREQ),
        .oSTART(oSTART), .oCH(oCH), .iDONE(iDONE), .iDATA(iDATA),
        .oVALID(oVALID), .oVCH(oVCH), .oVDATA(oVDATA), .oBUSY(oBUSY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (oVALID) n_valids <= n_valids + 1;
        if (oSTART) n_starts <= n_starts + 1;
    end

    typedef struct {
        logic        run;
        logic [7:0]  mask;
        logic [7:0]  pre;
        logic [7:0]  req;
        logic [11:0] data;
        int          exp_wait;
        logic [2:0]  exp_ch;
        logic        exp_v;
        logic [2:0]  exp_vch;
        logic [11:0] exp_vd;
    } vec_t;

    function automatic vec_t mk(input logic run, input logic [7:0] mask, input logic [7:0] pre,
                                input logic [7:0] req, input logic [11:0] data, input int ew,
                                input logic [2:0] ech, input logic ev, input logic [2:0] evch,
                                input logic [11:0] evd);
        vec_t v;
        v.run = run; v.mask = mask; v.pre = pre; v.req = req; v.data = data;
        v.exp_wait = ew; v.exp_ch = ech; v.exp_v = ev; v.exp_vch = evch; v.exp_vd = evd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Optionally pulse a request, wait for the launch, pulse req during ISSUE,
    // answer 18 cycles after oSTART and sample the registered strobe.
    task automatic do_frame(input logic [7:0] pre, input logic [7:0] req, input logic [11:0] data,
                            output int waited, output logic [2:0] ch, output logic got_v,
                            output logic [2:0] vch, output logic [11:0] vd, output bit ok);
        waited = 0; ch = 3'd0; got_v = 1'b0; vch = 3'd0; vd = 12'd0; ok = 1'b1;
        if (pre != 8'd0) begin
            iREQ = pre;
            step();
            iREQ = 8'd0;
        end
        while (!oSTART && waited < 300) begin
            step();
            waited++;
        end
        if (!oSTART) begin
            check("start_seen", 32'(oSTART), 32'd1);
            ok = 1'b0;
            return;
        end
        ch   = oCH;
        iREQ = req;
        for (int k = 0; k < 18; k++) begin
            step();
            iREQ = 8'd0;
        end
        iDONE = 1'b1;
        iDATA = data;
        step();
        iDONE = 1'b0;
        got_v = oVALID;
        vch   = oVCH;
        vd    = oVDATA;
    endtask

    vec_t        tbl [9];
    int          w;
    logic [2:0]  ch, vch;
    logic        gv;
    logic [11:0] vd;
    bit          ok;
    int          nv, ns;

    initial begin
        iRST = 1'b0; iRUN = 1'b0; iEN_MASK = 8'd0; iREQ = 8'd0; iDONE = 1'b0; iDATA = 12'd0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_start", 32'(oSTART), 32'd0);
        check("rst_ch",    32'(oCH),    32'd0);
        check("rst_valid", 32'(oVALID), 32'd0);
        check("rst_vch",   32'(oVCH),   32'd0);
        check("rst_vdata", 32'(oVDATA), 32'd0);
        check("rst_busy",  32'(oBUSY),  32'd0);
        check("rst_err",   32'(oERR),   32'd0);
        iRST = 1'b1;
        step();
        step();

        // Scan 0,2,0,2 with ch7 preempting, a flush, then a lone request on ch5 plus its flush
        tbl[0] = mk(1'b1, 8'h05, 8'h00, 8'h00, 12'h101, 1, 3'd0, 1'b0, 3'd0, 12'h000);
        tbl[1] = mk(1'b1, 8'h05, 8'h00, 8'h00, 12'h102, 2, 3'd2, 1'b1, 3'd0, 12'h102);
        tbl[2] = mk(1'b1, 8'h05, 8'h00, 8'h00, 12'h103, 2, 3'd0, 1'b1, 3'd2, 12'h103);
        tbl[3] = mk(1'b1, 8'h05, 8'h00, 8'h80, 12'h104, 2, 3'd2, 1'b1, 3'd0, 12'h104);
        tbl[4] = mk(1'b1, 8'h05, 8'h00, 8'h00, 12'h105, 2, 3'd7, 1'b1, 3'd2, 12'h105);
        tbl[5] = mk(1'b1, 8'h05, 8'h00, 8'h00, 12'h106, 2, 3'd0, 1'b1, 3'd7, 12'h106);
        tbl[6] = mk(1'b0, 8'h05, 8'h00, 8'h00, 12'h107, 2, 3'd0, 1'b1, 3'd0, 12'h107);
        tbl[7] = mk(1'b0, 8'h00, 8'h20, 8'h00, 12'hA5A, 1, 3'd5, 1'b0, 3'd0, 12'h000);
        tbl[8] = mk(1'b0, 8'h00, 8'h00, 8'h00, 12'h3C3, 2, 3'd5, 1'b1, 3'd5, 12'h3C3);

        nv = 0;
        for (int i = 0; i < 9; i++) begin
            iRUN     = tbl[i].run;
            iEN_MASK = tbl[i].mask;
            if (i == 8) nv = n_valids;
            do_frame(tbl[i].pre, tbl[i].req, tbl[i].data, w, ch, gv, vch, vd, ok);
            if (!ok) continue;
            check($sformatf("v%0d_wait", i), 32'(w),  32'(tbl[i].exp_wait));
            check($sformatf("v%0d_ch", i),   32'(ch), 32'(tbl[i].exp_ch));
            check($sformatf("v%0d_valid", i), 32'(gv), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                check($sformatf("v%0d_vch", i),  32'(vch), 32'(tbl[i].exp_vch));
                check($sformatf("v%0d_vdata", i), 32'(vd), 32'(tbl[i].exp_vd));
            end
        end
        repeat (10) step();
        check("single_one_valid", 32'(n_valids - nv), 32'd1);
        check("single_idle_busy", 32'(oBUSY), 32'd0);

        // Request re-asserted in its own ISSUE cycle: issued twice, then only a flush
        do_frame(8'h08, 8'h08, 12'h333, w, ch, gv, vch, vd, ok);
        check("col1_ch", 32'(ch), 32'd3);
        check("col1_valid", 32'(gv), 32'd0);
        do_frame(8'h00, 8'h00, 12'h444, w, ch, gv, vch, vd, ok);
        check("col2_ch", 32'(ch), 32'd3);
        check("col2_vch", 32'(vch), 32'd3);
        check("col2_vdata", 32'(vd), 32'h444);
        do_frame(8'h00, 8'h00, 12'h555, w, ch, gv, vch, vd, ok);
        check("col3_flush_ch", 32'(ch), 32'd3);
        check("col3_vdata", 32'(vd), 32'h555);
        ns = n_starts;
        repeat (30) step();
        check("col_no_extra_start", 32'(n_starts - ns), 32'd0);
        check("col_idle_busy", 32'(oBUSY), 32'd0);

        // Timeout: request latency, 64 WAIT cycles, sticky error, no flush afterwards
        iREQ = 8'h02;
        step();
        iREQ = 8'h00;
        check("lat_no_start_yet", 32'(oSTART), 32'd0);
        step();
        check("lat_start", 32'(oSTART), 32'd1);
        check("lat_ch", 32'(oCH), 32'd1);
        check("lat_busy", 32'(oBUSY), 32'd1);
        nv = n_valids;
        repeat (64) step();
        check("tmo_err_before", 32'(oERR), 32'd0);
        check("tmo_busy_before", 32'(oBUSY), 32'd1);
        step();
        check("tmo_err_set", 32'(oERR), 32'd1);
        ns = n_starts;
        repeat (20) step();
        check("tmo_no_valid", 32'(n_valids - nv), 32'd0);
        check("tmo_no_flush", 32'(n_starts - ns), 32'd0);
        check("tmo_idle_busy", 32'(oBUSY), 32'd0);
        do_frame(8'h10, 8'h00, 12'h777, w, ch, gv, vch, vd, ok);
        check("tmo_next_ch", 32'(ch), 32'd4);
        check("tmo_next_valid", 32'(gv), 32'd0);
        do_frame(8'h00, 8'h00, 12'h888, w, ch, gv, vch, vd, ok);
        check("tmo_flush_vch", 32'(vch), 32'd4);
        check("tmo_flush_vdata", 32'(vd), 32'h888);
        check("tmo_err_sticky", 32'(oERR), 32'd1);

        // Reset in the middle of WAIT, then a stale iDONE
        iREQ = 8'h04;
        step();
        iREQ = 8'h00;
        step();
        check("rw_start", 32'(oSTART), 32'd1);
        check("rw_ch", 32'(oCH), 32'd2);
        repeat (5) step();
        iRST = 1'b0;
        #1;
        check("rw_ch0",    32'(oCH),    32'd0);
        check("rw_vch0",   32'(oVCH),   32'd0);
        check("rw_vdata0", 32'(oVDATA), 32'd0);
        check("rw_busy0",  32'(oBUSY),  32'd0);
        check("rw_err0",   32'(oERR),   32'd0);
        check("rw_start0", 32'(oSTART), 32'd0);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        step();
        ns = n_starts;
        nv = n_valids;
        iDONE = 1'b1;
        iDATA = 12'hFFF;
        step();
        iDONE = 1'b0;
        check("rw_stale_valid", 32'(oVALID), 32'd0);
        check("rw_stale_vdata", 32'(oVDATA), 32'd0);
        repeat (20) step();
        check("rw_no_start", 32'(n_starts - ns), 32'd0);
        check("rw_no_valid", 32'(n_valids - nv), 32'd0);
        check("rw_idle_busy", 32'(oBUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
